// File: rtl/life_state_controller_if.sv
// Game-control bundle between the life/state controller and the game-logic and renderer stages.
// master drives the player/collision inputs; slave is the controller.
interface life_state_controller_if;
    logic       start;
    logic       pacman_is_dead;
    logic       game_rst;
    logic       freeze;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state;
    logic       death_blink;

    modport master (
        output start, pacman_is_dead,
        input  game_rst, freeze, lives, game_over, state, death_blink
    );

    modport slave (
        input  start, pacman_is_dead,
        output game_rst, freeze, lives, game_over, state, death_blink
    );
endinterface

// File: rtl/life_state_controller.sv
// Pac-Man life/state sequencer IDLE->READY->PLAY->DYING->(READY|OVER); DEATH_BLINK_EN adds the death blink.
// Latency: outputs change one clk edge after the causing input; all outputs come from flops.
// Backpressure: none; start is edge-detected and pacman_is_dead is honoured only in PLAY.
module life_state_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int READY_CYCLES = 50_000_000,
    parameter int DEATH_CYCLES = 100_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    life_state_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [26:0] READY_LAST = 27'(READY_CYCLES - 1);
    localparam logic [26:0] DEATH_LAST = 27'(DEATH_CYCLES - 1);
    localparam logic [1:0]  LIVES_RST  = 2'(LIVES_INIT);

    if (LIVES_INIT < 1 || LIVES_INIT > 3) begin : g_bad_lives
        $error("LIVES_INIT must be 1..3");
    end
    if (READY_CYCLES < 1 || READY_CYCLES >= 2**26) begin : g_bad_ready
        $error("READY_CYCLES must be 1..2^26-1");
    end
    if (DEATH_CYCLES < 1 || DEATH_CYCLES >= 2**27) begin : g_bad_death
        $error("DEATH_CYCLES must be 1..2^27-1");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
        $error("BLINK_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic        start_q;
    logic [1:0]  lives_q, lives_d;
    logic        start_rise;

    assign start_rise = bus.start & ~start_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ST_IDLE:  if (start_rise) state_d = ST_READY;
            ST_READY: if (cnt_q == READY_LAST) state_d = ST_PLAY;
            ST_PLAY: begin
                if (bus.pacman_is_dead) begin
                    state_d = ST_DYING;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end
            end
            ST_DYING: begin
                if (cnt_q == DEATH_LAST) state_d = (lives_q == 2'd0) ? ST_OVER : ST_READY;
            end
            ST_OVER:  if (start_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // A new game always starts with a full stock, including the OVER->IDLE return.
        if (state_d == ST_IDLE) lives_d = LIVES_RST;
        cnt_d = (state_d != state_q) ? 27'd0 : cnt_q + 27'd1;
    end

    // start_q resets high so a button held through reset is not taken as a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 27'd0;
            start_q <= 1'b1;
            lives_q <= LIVES_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= bus.start;
            lives_q <= lives_d;
        end
    end

    assign bus.game_rst  = (state_q != ST_PLAY) && (state_q != ST_DYING);
    assign bus.freeze    = (state_q != ST_PLAY);
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.state     = state_q;
    assign bus.lives     = lives_q;

`ifdef DEATH_BLINK_EN
    localparam logic [26:0] BLINK_LAST = 27'(BLINK_CYCLES - 1);

    logic [26:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;

    always_comb begin
        blink_cnt_d = 27'd0;
        blink_d     = 1'b0;
        if (state_d == ST_DYING) begin
            if (state_q != ST_DYING) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 27'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= 27'd0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.death_blink = blink_q;
`else
    assign bus.death_blink = 1'b0;
`endif

endmodule

// File: tb/tb_life_state_controller.sv
// Randomised scoreboard bench for life_state_controller against a cycle-timeline reference model.
module tb_life_state_controller;

    localparam int LI = 3;
    localparam int RC = 4;
    localparam int DC = 8;
    localparam int BC = 2;

    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_PLAY  = 2;
    localparam int M_DYING = 3;
    localparam int M_OVER  = 4;

    logic clk = 1'b0;
    logic rst;

    life_state_controller_if bus ();

    life_state_controller #(
        .LIVES_INIT   (LI),
        .READY_CYCLES (RC),
        .DEATH_CYCLES (DC),
        .BLINK_CYCLES (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode plus the edge number at which it was entered.
    int m_mode  = M_IDLE;
    int m_lives = LI;
    int m_entry = 0;
    int cyc     = 0;
    bit m_prev_start = 1'b1;

    logic [8:0] exp_q[$];

    function automatic logic [8:0] model_outputs();
        bit gr, fr, go, bl;
        gr = (m_mode == M_IDLE) || (m_mode == M_READY) || (m_mode == M_OVER);
        fr = (m_mode != M_PLAY);
        go = (m_mode == M_OVER);
        bl = 1'b0;
`ifdef DEATH_BLINK_EN
        bl = (m_mode == M_DYING) && ((((cyc - m_entry) / BC) % 2) == 0);
`endif
        return {gr, fr, 2'(m_lives), go, 3'(m_mode), bl};
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit r, input bit s, input bit d);
        bit press;
        int dwell;
        int nxt;
        cyc++;
        if (r) begin
            m_mode       = M_IDLE;
            m_lives      = LI;
            m_prev_start = 1'b1;
            m_entry      = cyc;
        end else begin
            press        = s && !m_prev_start;
            m_prev_start = s;
            dwell        = cyc - m_entry;
            nxt          = m_mode;
            case (m_mode)
                M_IDLE:  if (press) nxt = M_READY;
                M_READY: if (dwell == RC) nxt = M_PLAY;
                M_PLAY:  if (d) begin nxt = M_DYING; m_lives = m_lives - 1; end
                M_DYING: if (dwell == DC) nxt = (m_lives == 0) ? M_OVER : M_READY;
                M_OVER:  if (press) nxt = M_IDLE;
                default: nxt = M_IDLE;
            endcase
            if (nxt != m_mode) begin
                m_mode  = nxt;
                m_entry = cyc;
                if (nxt == M_IDLE) m_lives = LI;
            end
        end
        exp_q.push_back(model_outputs());
    endtask

    task automatic drive(input bit r, input bit s, input bit d);
        @(negedge clk);
        rst                = r;
        bus.start          = s;
        bus.pacman_is_dead = d;
        model_step(r, s, d);
    endtask

    task automatic run_until(input int mode, input int budget);
        int n;
        n = 0;
        while (int'(bus.state) != mode && n < budget) begin
            drive(1'b0, 1'b0, 1'b0);
            n++;
        end
        n_checks++;
        if (int'(bus.state) != mode) begin
            n_fail++;
            $display("FAIL wait_state: state=%0d, required %0d within %0d cycles", bus.state, mode, budget);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh output snapshot just after the edge.
    initial begin
        logic [8:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.game_rst, bus.freeze, bus.lives, bus.game_over, bus.state, bus.death_blink};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs edge %0d: got rst/frz/lives/over/state/blink=%b/%b/%0d/%b/%0d/%b, expected %b/%b/%0d/%b/%0d/%b",
                             cyc - exp_q.size(), g[8], g[7], g[6:5], g[4], g[3:1], g[0],
                             e[8], e[7], e[6:5], e[4], e[3:1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [8:0] g;
        rst                = 1'b1;
        bus.start          = 1'b1;
        bus.pacman_is_dead = 1'b0;

        // Button held through reset and release is not a press.
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);          // press during READY is ignored
        drive(1'b0, 1'b0, 1'b0);
        run_until(M_PLAY, 20);

        // Three deaths, with stray death pulses and presses outside PLAY.
        for (int k = 0; k < 3; k++) begin
            repeat (2) drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b1, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
            if (k < 2) run_until(M_PLAY, 40);
            else       run_until(M_OVER, 40);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        run_until(M_IDLE, 5);

        // Asynchronous reset in the middle of DYING.
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        run_until(M_PLAY, 20);
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        g = {bus.game_rst, bus.freeze, bus.lives, bus.game_over, bus.state, bus.death_blink};
        n_checks++;
        if (g !== 9'b1_1_11_0_000_0) begin
            n_fail++;
            $display("FAIL async_reset: outputs %b, required %b", g, 9'b1_1_11_0_000_0);
        end
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Random play.
        for (int i = 0; i < 3000; i++) begin
            drive(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected snapshots left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/life_state_controller.md
LIFE_STATE_CONTROLLER -- requirements
Module: life_state_controller

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start; legal range 1..3.
REQ-002 Parameter READY_CYCLES, default 50_000_000: hold time of the READY state; legal range 1..2^26-1.
REQ-003 Parameter DEATH_CYCLES, default 100_000_000: freeze time after a death; legal range 1..2^27-1.
REQ-004 Parameter BLINK_CYCLES, default 12_500_000: half-period of the death blink.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; asynchronous and active-high.
REQ-007 start  input  1  level from any player button; only its rising edge is used.
REQ-008 pacman_is_dead  input  1  collision flag from the game-logic stage.
REQ-009 game_rst  output  1  active-high reset driven into the game-logic rst input.
REQ-010 freeze  output  1  high means the game-logic stage and renderer must hold sprite positions.
REQ-011 lives  output  2  remaining lives.
REQ-012 game_over  output  1  high only in the OVER state.
REQ-013 state  output  3  one-hot-free encoding: IDLE=0, READY=1, PLAY=2, DYING=3, OVER=4.
REQ-014 death_blink  output  1  Pac-Man visibility toggle during DYING.

Function
REQ-015 The block SHALL register start each cycle (start_q) and define start_rise = start & ~start_q.
REQ-016 In IDLE: game_rst=1, freeze=1, lives=LIVES_INIT; on start_rise the block SHALL go to READY.
REQ-017 In READY: game_rst=1, freeze=1; after exactly READY_CYCLES cycles in READY the block SHALL go to PLAY.
REQ-018 In PLAY: game_rst=0, freeze=0; pacman_is_dead sampled high on a clock edge SHALL move to DYING and decrement lives on that same edge.
REQ-019 pacman_is_dead SHALL be ignored in every state except PLAY; a death when lives is already 0 is impossible by construction and lives SHALL never wrap below 0.
REQ-020 In DYING: game_rst=0, freeze=1; after exactly DEATH_CYCLES cycles, go to OVER if lives==0, else to READY.
REQ-021 In OVER: game_over=1, freeze=1, game_rst=1; on start_rise go to IDLE.
REQ-022 A single 27-bit dwell counter SHALL clear on every state transition, increment each cycle, and trigger exit when it equals the state's cycle count minus 1.
REQ-023 start_rise in READY, PLAY or DYING SHALL have no effect.
REQ-024 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-025 An out-of-range state value SHALL transition to IDLE on the next edge.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, start_q=1 (a held button is not a press), lives=LIVES_INIT, game_rst=1, freeze=1, game_over=0, death_blink=0.
REQ-027 Reset asserted mid-operation (any state) SHALL take effect immediately and asynchronously; release SHALL resume in IDLE.

Configuration
REQ-028 Macro DEATH_BLINK_EN: when defined, death_blink SHALL be 1 on DYING entry and toggle every BLINK_CYCLES cycles while in DYING, forced to 0 in all other states; when undefined, death_blink SHALL be constant 0 and the blink counter SHALL not be built.

Verification (LIVES_INIT=3, READY_CYCLES=4, DEATH_CYCLES=8, BLINK_CYCLES=2)
REQ-029 Release rst, pulse start 1 cycle -> state IDLE->READY next edge, game_rst=1 for 4 cycles, then state=2, game_rst=0, lives=3.
REQ-030 In PLAY assert pacman_is_dead 1 cycle -> state=3, lives=2, freeze=1 for 8 cycles, then state=1 (READY).
REQ-031 Three deaths from start -> after third DYING, state=4, game_over=1, lives=0; further pacman_is_dead pulses leave lives=0.
REQ-032 Hold start high through reset release -> state stays IDLE; release then press start -> READY.
REQ-033 Assert rst asynchronously mid-DYING (between clock edges) -> outputs reach reset values before the next edge; lives=3.
REQ-034 With DEATH_BLINK_EN defined, death in PLAY -> death_blink 1,1,0,0,1,1,0,0 over 8 DYING cycles, 0 after exit; undefined -> always 0.
